// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared encodings for the pipelined MIPS controller and datapath.
//   - opcode / funct values decoded in D
//   - ALU control, ALU B-source, next-PC select and load/store mask encodings
//   - packed control bundles carried through the E, M and W pipeline registers.
//     The field order in each struct is the bit layout the datapath relies on
//     (first field = MSBs).
package ctrl_pkg;

    localparam int CTRL_ALU_W  = 4;
    localparam int CTRL_MASK_W = 2;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL   = 6'h00;
    localparam logic [5:0] F_SRL   = 6'h02;
    localparam logic [5:0] F_SRA   = 6'h03;
    localparam logic [5:0] F_JR    = 6'h08;
    localparam logic [5:0] F_MFHI  = 6'h10;
    localparam logic [5:0] F_MFLO  = 6'h12;
    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_ADD   = 6'h20;
    localparam logic [5:0] F_ADDU  = 6'h21;
    localparam logic [5:0] F_SUB   = 6'h22;
    localparam logic [5:0] F_SUBU  = 6'h23;
    localparam logic [5:0] F_AND   = 6'h24;
    localparam logic [5:0] F_OR    = 6'h25;
    localparam logic [5:0] F_XOR   = 6'h26;
    localparam logic [5:0] F_NOR   = 6'h27;
    localparam logic [5:0] F_SLT   = 6'h2A;
    localparam logic [5:0] F_SLTU  = 6'h2B;

    // ALU control
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_SLT  = 4'd6;
    localparam logic [3:0] ALU_SLTU = 4'd7;
    localparam logic [3:0] ALU_SLL  = 4'd8;
    localparam logic [3:0] ALU_SRL  = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;
    localparam logic [3:0] ALU_LUI  = 4'd11;

    // ALU B-operand source
    localparam logic [1:0] SRC_REG   = 2'd0;
    localparam logic [1:0] SRC_IMM   = 2'd1;
    localparam logic [1:0] SRC_SHAMT = 2'd2;

    // Next-PC select
    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;
    localparam logic [1:0] PC_REG    = 2'd3;

    // Store mask modes (M stage)
    localparam logic [1:0] ST_NONE = 2'd0;
    localparam logic [1:0] ST_WORD = 2'd1;
    localparam logic [1:0] ST_HALF = 2'd2;
    localparam logic [1:0] ST_BYTE = 2'd3;

    // Load extract modes (M stage)
    localparam logic [1:0] LD_WORD = 2'd0;
    localparam logic [1:0] LD_BYTE = 2'd1;
    localparam logic [1:0] LD_HALF = 2'd2;

    // Full decoded bundle, held in the E register
    typedef struct packed {
        logic [CTRL_ALU_W-1:0]  alu_control;
        logic [1:0]             alu_src;
        logic                   reg_dst;
        logic                   sign_or_zero;
        logic                   branch_eq;
        logic                   branch_ne;
        logic                   jump;
        logic                   jump_reg;
        logic                   muldiv;
        logic                   mfhilo;
        logic                   mem_write;
        logic [CTRL_MASK_W-1:0] mask_control;
        logic [CTRL_MASK_W-1:0] lblh_enable;
        logic                   reg_write;
        logic                   mem_to_reg;
        logic                   jal;
    } ctrl_t;

    // Subset still needed after E
    typedef struct packed {
        logic                   mem_write;
        logic [CTRL_MASK_W-1:0] mask_control;
        logic [CTRL_MASK_W-1:0] lblh_enable;
        logic                   reg_write;
        logic                   mem_to_reg;
        logic                   jal;
    } m_ctrl_t;

    // Subset still needed after M
    typedef struct packed {
        logic reg_write;
        logic mem_to_reg;
        logic jal;
    } w_ctrl_t;

endpackage

// File: rtl/mips_ctrl_decode.sv
// mips_ctrl_decode: combinational merged main / ALU / mask decoder.
// Ports:
//   op_i, funct_i  - opcode and funct of the D-stage instruction
//   ctrl_o         - decoded control bundle (all zero for an illegal encoding)
//   illegal_o      - encoding is not supported by this core
module mips_ctrl_decode import ctrl_pkg::*; #(
    parameter bit HAS_MULDIV = 1'b1
) (
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output ctrl_t      ctrl_o,
    output logic       illegal_o
);

    ctrl_t ctrl_s;
    logic  illegal_s;

    // Main + ALU + mask decode
    always_comb begin
        ctrl_s    = '0;
        illegal_s = 1'b0;
        case (op_i)
            OP_RTYPE: begin
                ctrl_s.reg_dst   = 1'b1;
                ctrl_s.reg_write = 1'b1;
                case (funct_i)
                    F_ADD, F_ADDU: ctrl_s.alu_control = ALU_ADD;
                    F_SUB, F_SUBU: ctrl_s.alu_control = ALU_SUB;
                    F_AND:         ctrl_s.alu_control = ALU_AND;
                    F_OR:          ctrl_s.alu_control = ALU_OR;
                    F_XOR:         ctrl_s.alu_control = ALU_XOR;
                    F_NOR:         ctrl_s.alu_control = ALU_NOR;
                    F_SLT:         ctrl_s.alu_control = ALU_SLT;
                    F_SLTU:        ctrl_s.alu_control = ALU_SLTU;
                    F_SLL: begin
                        ctrl_s.alu_control = ALU_SLL;
                        ctrl_s.alu_src     = SRC_SHAMT;
                    end
                    F_SRL: begin
                        ctrl_s.alu_control = ALU_SRL;
                        ctrl_s.alu_src     = SRC_SHAMT;
                    end
                    F_SRA: begin
                        ctrl_s.alu_control = ALU_SRA;
                        ctrl_s.alu_src     = SRC_SHAMT;
                    end
                    F_JR: begin
                        ctrl_s.reg_write = 1'b0;
                        ctrl_s.jump_reg  = 1'b1;
                    end
                    F_MFHI, F_MFLO: begin
                        if (HAS_MULDIV) ctrl_s.mfhilo = 1'b1;
                        else            illegal_s     = 1'b1;
                    end
                    F_MULT, F_MULTU, F_DIV, F_DIVU: begin
                        // Result lands in HI/LO, not the register file
                        ctrl_s.reg_write = 1'b0;
                        ctrl_s.reg_dst   = 1'b0;
                        if (HAS_MULDIV) ctrl_s.muldiv = 1'b1;
                        else            illegal_s     = 1'b1;
                    end
                    default: illegal_s = 1'b1;
                endcase
            end
            OP_J:   ctrl_s.jump = 1'b1;
            OP_JAL: begin
                ctrl_s.jump      = 1'b1;
                ctrl_s.jal       = 1'b1;
                ctrl_s.reg_write = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                ctrl_s.branch_eq    = (op_i == OP_BEQ);
                ctrl_s.branch_ne    = (op_i == OP_BNE);
                ctrl_s.alu_control  = ALU_SUB;
                ctrl_s.sign_or_zero = 1'b1;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI: begin
                ctrl_s.alu_control  = (op_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
                ctrl_s.alu_src      = SRC_IMM;
                ctrl_s.sign_or_zero = 1'b1;
                ctrl_s.reg_write    = 1'b1;
            end
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                case (op_i)
                    OP_ANDI: ctrl_s.alu_control = ALU_AND;
                    OP_ORI:  ctrl_s.alu_control = ALU_OR;
                    OP_XORI: ctrl_s.alu_control = ALU_XOR;
                    default: ctrl_s.alu_control = ALU_LUI;
                endcase
                ctrl_s.alu_src   = SRC_IMM;
                ctrl_s.reg_write = 1'b1;
            end
            OP_LB, OP_LH, OP_LW: begin
                case (op_i)
                    OP_LB:   ctrl_s.lblh_enable = LD_BYTE;
                    OP_LH:   ctrl_s.lblh_enable = LD_HALF;
                    default: ctrl_s.lblh_enable = LD_WORD;
                endcase
                ctrl_s.alu_control  = ALU_ADD;
                ctrl_s.alu_src      = SRC_IMM;
                ctrl_s.sign_or_zero = 1'b1;
                ctrl_s.reg_write    = 1'b1;
                ctrl_s.mem_to_reg   = 1'b1;
            end
            OP_SB, OP_SH, OP_SW: begin
                case (op_i)
                    OP_SB:   ctrl_s.mask_control = ST_BYTE;
                    OP_SH:   ctrl_s.mask_control = ST_HALF;
                    default: ctrl_s.mask_control = ST_WORD;
                endcase
                ctrl_s.alu_control  = ALU_ADD;
                ctrl_s.alu_src      = SRC_IMM;
                ctrl_s.sign_or_zero = 1'b1;
                ctrl_s.mem_write    = 1'b1;
            end
            default: illegal_s = 1'b1;
        endcase
    end

    // An illegal encoding must not leak partial controls into the pipeline
    assign ctrl_o    = illegal_s ? ctrl_t'('0) : ctrl_s;
    assign illegal_o = illegal_s;

endmodule

// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: pipelined MIPS control unit. Decodes in D and carries the
// control bundle through the E, M and W registers, resolves branches/jumps in
// E, and sequences the multi-cycle HI/LO unit.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   instr_valid_d, op_d, funct_d     - D-stage instruction
//   zero_e                           - ALU zero flag in E
//   stall_ext                        - external freeze of the whole pipeline
//   *_e / *_m / *_w                  - stage control outputs (0 for bubbles)
//   stall_fd, flush_fd               - F/D register hold / squash
//   illegal_e                        - one-cycle illegal-instruction pulse
//   muldiv_busy                      - HI/LO unit busy
module mips_pipe_ctrl import ctrl_pkg::*; #(
    parameter int ALU_CTRL_W = 4,
    parameter int MASK_W     = 2,
    parameter bit HAS_MULDIV = 1'b1,
    parameter int MULDIV_LAT = 32,
    parameter int CNT_W      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_valid_d,
    input  logic [5:0]            op_d,
    input  logic [5:0]            funct_d,
    input  logic                  zero_e,
    input  logic                  stall_ext,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic [1:0]            alu_src_e,
    output logic                  reg_dst_e,
    output logic                  sign_or_zero_e,
    output logic                  muldiv_start_e,
    output logic [1:0]            pc_sel_e,
    output logic                  mem_write_m,
    output logic [MASK_W-1:0]     mask_control_m,
    output logic [MASK_W-1:0]     lblh_enable_m,
    output logic                  reg_write_w,
    output logic                  mem_to_reg_w,
    output logic                  jal_w,
    output logic                  stall_fd,
    output logic                  flush_fd,
    output logic                  illegal_e,
    output logic                  muldiv_busy
);

    ctrl_t      dec_s;
    logic       dec_illegal_s;
    ctrl_t      e_q, e_d;
    m_ctrl_t    m_q, m_d;
    w_ctrl_t    w_q, w_d;
    logic       e_valid_q, e_valid_d, m_valid_q, m_valid_d, w_valid_q, w_valid_d;
    logic       illegal_q, illegal_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic       busy_s, hz_s, taken_s, redirect_s, start_s;
    logic [1:0] pc_sel_s;

    mips_ctrl_decode #(.HAS_MULDIV(HAS_MULDIV)) u_decode (
        .op_i      (op_d),
        .funct_i   (funct_d),
        .ctrl_o    (dec_s),
        .illegal_o (dec_illegal_s)
    );

    // Hazard detection, redirect resolution and mult/div start
    always_comb begin
        busy_s  = (cnt_q != {CNT_W{1'b0}});
        // Anything touching HI/LO waits in E until the unit drains
        hz_s    = e_valid_q && (e_q.muldiv || e_q.mfhilo) && busy_s && !stall_ext;
        taken_s = (e_q.branch_eq && zero_e) || (e_q.branch_ne && !zero_e);
        if (!e_valid_q || stall_ext || hz_s) begin
            pc_sel_s = PC_PLUS4;
        end else if (e_q.jump_reg) begin
            pc_sel_s = PC_REG;
        end else if (e_q.jump) begin
            pc_sel_s = PC_JUMP;
        end else if (taken_s) begin
            pc_sel_s = PC_BRANCH;
        end else begin
            pc_sel_s = PC_PLUS4;
        end
        redirect_s = (pc_sel_s != PC_PLUS4);
        start_s    = e_valid_q && e_q.muldiv && !stall_ext && !hz_s;
    end

    // Next state of the stage registers and busy counter
    always_comb begin
        e_d       = e_q;
        e_valid_d = e_valid_q;
        illegal_d = illegal_q;
        m_d       = m_q;
        m_valid_d = m_valid_q;
        w_d       = w_q;
        w_valid_d = w_valid_q;

        // Counter runs even while frozen: the HI/LO unit is not stalled by memory
        if (start_s) begin
            cnt_d = CNT_W'(MULDIV_LAT);
        end else if (busy_s) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        if (!stall_ext) begin
            w_valid_d    = m_valid_q;
            w_d.reg_write  = m_q.reg_write;
            w_d.mem_to_reg = m_q.mem_to_reg;
            w_d.jal        = m_q.jal;
            if (hz_s) begin
                // E holds; a bubble goes into M
                m_valid_d = 1'b0;
                m_d       = '0;
            end else begin
                m_valid_d        = e_valid_q;
                m_d.mem_write    = e_q.mem_write;
                m_d.mask_control = e_q.mask_control;
                m_d.lblh_enable  = e_q.lblh_enable;
                m_d.reg_write    = e_q.reg_write;
                m_d.mem_to_reg   = e_q.mem_to_reg;
                m_d.jal          = e_q.jal;
                // Redirect squashes the wrong-path instruction currently in D
                e_valid_d = instr_valid_d && !dec_illegal_s && !redirect_s;
                illegal_d = instr_valid_d && dec_illegal_s && !redirect_s;
                e_d       = e_valid_d ? dec_s : ctrl_t'('0);
            end
        end else begin
            e_valid_d = e_valid_q;
        end
    end

    // Stage registers and busy counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_q       <= '0;
            e_valid_q <= 1'b0;
            illegal_q <= 1'b0;
            m_q       <= '0;
            m_valid_q <= 1'b0;
            w_q       <= '0;
            w_valid_q <= 1'b0;
            cnt_q     <= {CNT_W{1'b0}};
        end else begin
            e_q       <= e_d;
            e_valid_q <= e_valid_d;
            illegal_q <= illegal_d;
            m_q       <= m_d;
            m_valid_q <= m_valid_d;
            w_q       <= w_d;
            w_valid_q <= w_valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign alu_control_e  = e_valid_q ? ALU_CTRL_W'(e_q.alu_control) : {ALU_CTRL_W{1'b0}};
    assign alu_src_e      = e_valid_q ? e_q.alu_src : 2'b00;
    assign reg_dst_e      = e_valid_q & e_q.reg_dst;
    assign sign_or_zero_e = e_valid_q & e_q.sign_or_zero;
    assign muldiv_start_e = start_s;
    assign pc_sel_e       = pc_sel_s;
    assign mem_write_m    = m_valid_q & m_q.mem_write;
    assign mask_control_m = m_valid_q ? MASK_W'(m_q.mask_control) : {MASK_W{1'b0}};
    assign lblh_enable_m  = m_valid_q ? MASK_W'(m_q.lblh_enable) : {MASK_W{1'b0}};
    assign reg_write_w    = w_valid_q & w_q.reg_write;
    assign mem_to_reg_w   = w_valid_q & w_q.mem_to_reg;
    assign jal_w          = w_valid_q & w_q.jal;
    assign stall_fd       = stall_ext | hz_s;
    assign flush_fd       = redirect_s;
    assign illegal_e      = illegal_q;
    assign muldiv_busy    = busy_s;

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
module tb_mips_pipe_ctrl;
    import ctrl_pkg::*;

    localparam int LAT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       instr_valid_d, zero_e, stall_ext;
    logic [5:0] op_d, funct_d;
    logic [3:0] alu_control_e;
    logic [1:0] alu_src_e, pc_sel_e, mask_control_m, lblh_enable_m;
    logic       reg_dst_e, sign_or_zero_e, muldiv_start_e, mem_write_m;
    logic       reg_write_w, mem_to_reg_w, jal_w, stall_fd, flush_fd, illegal_e, muldiv_busy;

    always #5 clk = ~clk;

    mips_pipe_ctrl #(.ALU_CTRL_W(4), .MASK_W(2), .HAS_MULDIV(1'b1),
                     .MULDIV_LAT(LAT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_d(instr_valid_d), .op_d(op_d),
        .funct_d(funct_d), .zero_e(zero_e), .stall_ext(stall_ext),
        .alu_control_e(alu_control_e), .alu_src_e(alu_src_e), .reg_dst_e(reg_dst_e),
        .sign_or_zero_e(sign_or_zero_e), .muldiv_start_e(muldiv_start_e),
        .pc_sel_e(pc_sel_e), .mem_write_m(mem_write_m), .mask_control_m(mask_control_m),
        .lblh_enable_m(lblh_enable_m), .reg_write_w(reg_write_w),
        .mem_to_reg_w(mem_to_reg_w), .jal_w(jal_w), .stall_fd(stall_fd),
        .flush_fd(flush_fd), .illegal_e(illegal_e), .muldiv_busy(muldiv_busy)
    );

    localparam int S_ALU = 0, S_ALUSRC = 1, S_REGDST = 2, S_SIGN = 3, S_START = 4,
                   S_PCSEL = 5, S_MEMW = 6, S_MASK = 7, S_LBLH = 8, S_REGW = 9,
                   S_M2R = 10, S_JAL = 11, S_STALL = 12, S_FLUSH = 13, S_ILL = 14,
                   S_BUSY = 15, NSIG = 16;

    typedef struct {
        int    due;
        int    sig;
        int    val;
        string tag;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    function automatic logic [31:0] obs(input int s);
        case (s)
            S_ALU:    return 32'(alu_control_e);
            S_ALUSRC: return 32'(alu_src_e);
            S_REGDST: return 32'(reg_dst_e);
            S_SIGN:   return 32'(sign_or_zero_e);
            S_START:  return 32'(muldiv_start_e);
            S_PCSEL:  return 32'(pc_sel_e);
            S_MEMW:   return 32'(mem_write_m);
            S_MASK:   return 32'(mask_control_m);
            S_LBLH:   return 32'(lblh_enable_m);
            S_REGW:   return 32'(reg_write_w);
            S_M2R:    return 32'(mem_to_reg_w);
            S_JAL:    return 32'(jal_w);
            S_STALL:  return 32'(stall_fd);
            S_FLUSH:  return 32'(flush_fd);
            S_ILL:    return 32'(illegal_e);
            S_BUSY:   return 32'(muldiv_busy);
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    // Expectation due 'dly' cycles from the current one (0 = this cycle)
    task automatic expect_at(input int dly, input int sig, input int val, input string tag);
        exp_t e;
        e.due = cyc + dly;
        e.sig = sig;
        e.val = val;
        e.tag = tag;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic z, input logic st);
        instr_valid_d = v;
        op_d          = op;
        funct_d       = fn;
        zero_e        = z;
        stall_ext     = st;
    endtask

    task automatic bubble();
        drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b0);
    endtask

    // Compare everything due this cycle at the falling edge, then advance
    task automatic tick();
        @(negedge clk);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].due == cyc) begin
                check_val($sformatf("%s@%0d", exp_q[i].tag, cyc), obs(exp_q[i].sig),
                          32'(exp_q[i].val));
                exp_q.delete(i);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bubble();
        repeat (2) @(posedge clk);
        #1;
        for (int s = 0; s < NSIG; s++) check_val($sformatf("reset_sig%0d", s), obs(s), 32'd0);
        rst_n = 1'b1;

        // ADD: E after 1 cycle, W after 3
        drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
        expect_at(1, S_ALU, ALU_ADD, "add_alu");
        expect_at(1, S_REGDST, 1, "add_regdst");
        expect_at(1, S_ALUSRC, 0, "add_alusrc");
        expect_at(3, S_REGW, 1, "add_regw");
        expect_at(3, S_M2R, 0, "add_m2r");
        tick();
        bubble();
        expect_at(1, S_REGDST, 0, "bubble_e");
        expect_at(3, S_REGW, 0, "bubble_w");
        tick();
        // ORI: zero-extended immediate, OR
        drive(1'b1, 6'h0D, 6'h00, 1'b0, 1'b0);
        expect_at(1, S_ALU, ALU_OR, "ori_alu");
        expect_at(1, S_ALUSRC, 1, "ori_alusrc");
        expect_at(1, S_SIGN, 0, "ori_sign");
        expect_at(3, S_REGW, 1, "ori_regw");
        tick();
        // SB then LB
        drive(1'b1, 6'h28, 6'h00, 1'b0, 1'b0);
        expect_at(2, S_MEMW, 1, "sb_memw");
        expect_at(2, S_MASK, 3, "sb_mask");
        expect_at(3, S_REGW, 0, "sb_regw");
        tick();
        drive(1'b1, 6'h20, 6'h00, 1'b0, 1'b0);
        expect_at(2, S_LBLH, 1, "lb_lblh");
        expect_at(2, S_MEMW, 0, "lb_memw");
        expect_at(3, S_M2R, 1, "lb_m2r");
        tick();
        bubble();
        ticks(4);

        // BEQ taken: redirect + flush, wrong-path ADD becomes a bubble
        drive(1'b1, 6'h04, 6'h00, 1'b0, 1'b0);
        expect_at(1, S_PCSEL, 1, "beq_t_pcsel");
        expect_at(1, S_FLUSH, 1, "beq_t_flush");
        expect_at(1, S_ALU, ALU_SUB, "beq_alu");
        expect_at(3, S_REGW, 0, "beq_regw");
        tick();
        drive(1'b1, 6'h00, 6'h20, 1'b1, 1'b0);
        expect_at(1, S_REGDST, 0, "flushed_e");
        expect_at(1, S_PCSEL, 0, "after_flush_pcsel");
        expect_at(1, S_FLUSH, 0, "after_flush_flush");
        expect_at(3, S_REGW, 0, "flushed_w");
        tick();
        bubble();
        ticks(3);

        // BEQ not taken: ADD behind it proceeds
        drive(1'b1, 6'h04, 6'h00, 1'b0, 1'b0);
        tick();
        drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
        expect_at(0, S_PCSEL, 0, "beq_nt_pcsel");
        expect_at(0, S_FLUSH, 0, "beq_nt_flush");
        expect_at(1, S_REGDST, 1, "beq_nt_next_e");
        expect_at(3, S_REGW, 1, "beq_nt_next_w");
        tick();
        // BNE with zero_e = 0 is taken
        drive(1'b1, 6'h05, 6'h00, 1'b0, 1'b0);
        tick();
        bubble();
        expect_at(0, S_PCSEL, 1, "bne_t_pcsel");
        expect_at(0, S_FLUSH, 1, "bne_t_flush");
        tick();
        // JAL, then JR
        drive(1'b1, 6'h03, 6'h00, 1'b0, 1'b0);
        expect_at(1, S_PCSEL, 2, "jal_pcsel");
        expect_at(3, S_JAL, 1, "jal_w");
        expect_at(3, S_REGW, 1, "jal_regw");
        tick();
        bubble();
        tick();
        drive(1'b1, 6'h00, 6'h08, 1'b0, 1'b0);
        expect_at(1, S_PCSEL, 3, "jr_pcsel");
        expect_at(1, S_FLUSH, 1, "jr_flush");
        expect_at(3, S_REGW, 0, "jr_regw");
        tick();
        bubble();
        ticks(4);

        // J frozen in E: redirect suppressed until the freeze ends
        drive(1'b1, 6'h02, 6'h00, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 6'h00, 6'h00, 1'b0, 1'b1);
            expect_at(0, S_PCSEL, 0, "frz_j_pcsel");
            expect_at(0, S_FLUSH, 0, "frz_j_flush");
            expect_at(0, S_STALL, 1, "frz_j_stall");
            tick();
        end
        bubble();
        expect_at(0, S_PCSEL, 2, "unfrz_j_pcsel");
        expect_at(0, S_FLUSH, 1, "unfrz_j_flush");
        expect_at(0, S_STALL, 0, "unfrz_j_stall");
        tick();
        ticks(3);

        // MULT then MFLO: 4-cycle hazard stall, 4 bubbles into M
        drive(1'b1, 6'h00, 6'h18, 1'b0, 1'b0);
        expect_at(1, S_START, 1, "mult_start");
        expect_at(1, S_BUSY, 0, "mult_busy0");
        expect_at(2, S_BUSY, 1, "mult_busy1");
        expect_at(3, S_REGW, 0, "mult_regw");
        tick();
        drive(1'b1, 6'h00, 6'h12, 1'b0, 1'b0);
        expect_at(0, S_STALL, 0, "mflo_d_stall");
        tick();
        for (int k = 0; k < LAT; k++) begin
            drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
            expect_at(0, S_STALL, 1, "hz_stall");
            expect_at(0, S_START, 0, "hz_nostart");
            expect_at(0, S_REGDST, 1, "hz_mflo_held");
            expect_at(2, S_REGW, 0, "hz_bubble_w");
            tick();
        end
        drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
        expect_at(0, S_STALL, 0, "hz_release");
        expect_at(0, S_BUSY, 0, "hz_busy_done");
        expect_at(0, S_START, 0, "hz_start_once");
        expect_at(2, S_REGW, 1, "mflo_w");
        expect_at(1, S_REGDST, 1, "add_after_mflo_e");
        expect_at(3, S_REGW, 1, "add_after_mflo_w");
        tick();
        bubble();
        ticks(5);

        // LW in M frozen 3 cycles: everything holds, D is ignored
        drive(1'b1, 6'h23, 6'h00, 1'b0, 1'b0);
        expect_at(1, S_ALUSRC, 1, "lw_alusrc");
        expect_at(1, S_SIGN, 1, "lw_sign");
        expect_at(1, S_REGDST, 0, "lw_regdst");
        tick();
        drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
        tick();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 6'h3F, 6'h00, 1'b0, 1'b1);
            expect_at(0, S_STALL, 1, "frz_stall");
            expect_at(0, S_REGDST, 1, "frz_add_held");
            expect_at(0, S_M2R, 0, "frz_w_hold");
            expect_at(0, S_ILL, 0, "frz_no_ill");
            expect_at(0, S_FLUSH, 0, "frz_no_flush");
            tick();
        end
        bubble();
        expect_at(0, S_STALL, 0, "resume_stall");
        expect_at(0, S_REGDST, 1, "resume_add_e");
        expect_at(1, S_M2R, 1, "resume_lw_m2r");
        expect_at(1, S_REGW, 1, "resume_lw_regw");
        expect_at(2, S_REGW, 1, "resume_add_regw");
        expect_at(2, S_M2R, 0, "resume_add_m2r");
        tick();
        ticks(4);

        // Illegal opcode and illegal funct
        drive(1'b1, 6'h3F, 6'h00, 1'b0, 1'b0);
        expect_at(1, S_ILL, 1, "ill_op_pulse");
        expect_at(1, S_REGDST, 0, "ill_op_bubble");
        expect_at(2, S_ILL, 0, "ill_op_end");
        expect_at(2, S_MEMW, 0, "ill_op_memw");
        expect_at(3, S_REGW, 0, "ill_op_regw");
        tick();
        bubble();
        tick();
        drive(1'b1, 6'h00, 6'h3F, 1'b0, 1'b0);
        expect_at(1, S_ILL, 1, "ill_fn_pulse");
        expect_at(3, S_REGW, 0, "ill_fn_regw");
        tick();
        bubble();
        ticks(4);

        // Reset while the HI/LO unit is busy
        drive(1'b1, 6'h00, 6'h1A, 1'b0, 1'b0);
        expect_at(1, S_START, 1, "div_start");
        tick();
        bubble();
        tick();
        check_val("busy_before_rst", obs(S_BUSY), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        for (int s = 0; s < NSIG; s++) check_val($sformatf("midrst_sig%0d", s), obs(s), 32'd0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 6'h00, 6'h20, 1'b0, 1'b0);
        expect_at(0, S_BUSY, 0, "post_rst_busy");
        expect_at(1, S_REGDST, 1, "post_rst_add_e");
        expect_at(3, S_REGW, 1, "post_rst_add_w");
        tick();
        bubble();
        ticks(4);

        foreach (exp_q[i]) check_val({"unreached_", exp_q[i].tag}, 32'(cyc), 32'(exp_q[i].due));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
